// File: rtl/simple_top.sv
// LED pattern sequencer: a prescaler-driven step tick walks a 4-mode FSM
// (rotate left, rotate right, count up, blink), each mode lasting STEPS_PER_MODE ticks.
module simple_top #(
    parameter int unsigned DIV            = 4,
    parameter int unsigned STEPS_PER_MODE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] led_out
);

    localparam int unsigned PW = 16;
    localparam int unsigned SW = 8;
    localparam int unsigned LW = 4;

    // One-hot so that corrupted state is detectable and recoverable
    typedef enum logic [3:0] {
        LEFT  = 4'b0001,
        RIGHT = 4'b0010,
        COUNT = 4'b0100,
        BLINK = 4'b1000
    } mode_e;

    mode_e          mode_q, mode_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [SW-1:0]  step_q, step_d;
    logic [LW-1:0]  led_q, led_d;

    logic           tick_c;
    logic           last_c;
    logic           illegal_c;
    mode_e          next_mode_c;
    logic [LW-1:0]  start_pat_c;
    logic [LW-1:0]  rule_pat_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            step_q  <= '0;
            mode_q  <= LEFT;
            led_q   <= LW'(4'b0001);
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        tick_c      = (presc_q == PW'(DIV - 1));
        last_c      = (step_q == SW'(STEPS_PER_MODE - 1));
        presc_d     = tick_c ? '0 : presc_q + PW'(1);
        step_d      = step_q;
        mode_d      = mode_q;
        led_d       = led_q;
        illegal_c   = 1'b0;
        next_mode_c = LEFT;
        start_pat_c = LW'(4'b0001);
        rule_pat_c  = led_q;

        // Per-mode successor, its start pattern, and the in-mode update rule
        case (mode_q)
            LEFT: begin
                next_mode_c = RIGHT;
                start_pat_c = LW'(4'b1000);
                rule_pat_c  = {led_q[2:0], led_q[3]};
            end
            RIGHT: begin
                next_mode_c = COUNT;
                start_pat_c = LW'(4'b0000);
                rule_pat_c  = {led_q[0], led_q[3:1]};
            end
            COUNT: begin
                next_mode_c = BLINK;
                start_pat_c = LW'(4'b1111);
                rule_pat_c  = led_q + LW'(1);
            end
            BLINK: begin
                next_mode_c = LEFT;
                start_pat_c = LW'(4'b0001);
                rule_pat_c  = ~led_q;
            end
            default: begin
                illegal_c = 1'b1;
            end
        endcase

        if (illegal_c) begin
            mode_d = LEFT;
            step_d = '0;
            led_d  = LW'(4'b0001);
        end else if (tick_c) begin
            if (last_c) begin
                step_d = '0;
                mode_d = next_mode_c;
                led_d  = start_pat_c;
            end else begin
                step_d = step_q + SW'(1);
                led_d  = rule_pat_c;
            end
        end
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_simple_top.sv
// Bench for simple_top: default and corner-parameter instances checked against
// a per-cycle reference model through a scoreboard, plus fixed expected patterns.
module tb_simple_top;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] led_a, led_b, led_c;

    always #5 clk = ~clk;

    simple_top #(.DIV(4), .STEPS_PER_MODE(8))  dut_a (.clk(clk), .rst_n(rst_n), .led_out(led_a));
    simple_top #(.DIV(1), .STEPS_PER_MODE(1))  dut_b (.clk(clk), .rst_n(rst_n), .led_out(led_b));
    simple_top #(.DIV(1), .STEPS_PER_MODE(16)) dut_c (.clk(clk), .rst_n(rst_n), .led_out(led_c));

    typedef struct {
        int         presc;
        int         step;
        int         mode;
        logic [3:0] led;
    } mdl_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    mdl_t       m_a, m_b, m_c;
    logic [3:0] q_a[$], q_b[$], q_c[$];

    task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] start_pat(input int mode);
        case (mode)
            0:       return 4'b0001;
            1:       return 4'b1000;
            2:       return 4'b0000;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input bit rst, input int div, input int spm);
        mdl_t n = m;
        if (rst) begin
            n.presc = 0; n.step = 0; n.mode = 0; n.led = 4'b0001;
        end else if (m.presc == div - 1) begin
            n.presc = 0;
            if (m.step == spm - 1) begin
                n.step = 0;
                n.mode = (m.mode + 1) % 4;
                n.led  = start_pat(n.mode);
            end else begin
                n.step = m.step + 1;
                case (m.mode)
                    0:       n.led = {m.led[2:0], m.led[3]};
                    1:       n.led = {m.led[0], m.led[3:1]};
                    2:       n.led = m.led + 4'd1;
                    default: n.led = ~m.led;
                endcase
            end
        end else begin
            n.presc = m.presc + 1;
        end
        return n;
    endfunction

    // Drive one clock: push model predictions, then pop and compare after the edge
    task automatic cycle(input bit rn);
        logic [3:0] ea, eb, ec;
        rst_n = rn;
        m_a = mdl_next(m_a, !rn, 4, 8);
        m_b = mdl_next(m_b, !rn, 1, 1);
        m_c = mdl_next(m_c, !rn, 1, 16);
        q_a.push_back(m_a.led);
        q_b.push_back(m_b.led);
        q_c.push_back(m_c.led);
        @(posedge clk);
        #1;
        cyc++;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        ec = q_c.pop_front();
        check_val($sformatf("sb_a cyc%0d", cyc), led_a, ea);
        check_val($sformatf("sb_b cyc%0d", cyc), led_b, eb);
        check_val($sformatf("sb_c cyc%0d", cyc), led_c, ec);
    endtask

    logic [3:0] tick_tab [32];
    logic [3:0] corner_b [4];

    initial begin
        tick_tab = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                     4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                     4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                     4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000,
                     4'b0001};
        corner_b = '{4'b1000, 4'b0000, 4'b1111, 4'b0001};
        m_a = '{0, 0, 0, 4'b0001};
        m_b = '{0, 0, 0, 4'b0001};
        m_c = '{0, 0, 0, 4'b0001};
        rst_n = 1'b0;

        // Reset hold, then 128 clocks of free running with defaults
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0);
            check_val($sformatf("rst_hold%0d", i), led_a, 4'b0001);
        end
        for (int e = 1; e <= 128; e++) begin
            cycle(1'b1);
            if (e <= 3) check_val($sformatf("pre_tick e%0d", e), led_a, 4'b0001);
            if (e % 4 == 0) check_val($sformatf("tick%0d", e / 4), led_a, tick_tab[e / 4 - 1]);
            if (e <= 8) check_val($sformatf("corner_b e%0d", e), led_b, corner_b[(e - 1) % 4]);
            if (e == 32) check_val("corner_c count_start", led_c, 4'b0000);
            if (e > 32 && e <= 47) check_val($sformatf("corner_c e%0d", e), led_c, 4'(e - 32));
            if (e == 48) check_val("corner_c blink_start", led_c, 4'b1111);
        end

        // Mid-operation reset during COUNT at release edge 70
        cycle(1'b0);
        for (int e = 1; e <= 74; e++) begin
            cycle(e == 70 ? 1'b0 : 1'b1);
            if (e == 70) check_val("mid_rst e70", led_a, 4'b0001);
            if (e == 73) check_val("mid_rst e73", led_a, 4'b0001);
            if (e == 74) check_val("mid_rst e74", led_a, 4'b0010);
        end

        // Random run with occasional single-cycle resets
        for (int i = 0; i < 1200; i++) begin
            cycle($urandom_range(0, 49) == 0 ? 1'b0 : 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/simple_top.md
SIMPLE_TOP -- requirements
Module: simple_top

Interface
REQ-001 SHALL provide parameter DIV, default 4: prescaler terminal count, one step tick every DIV clocks; legal range 1..65535.
REQ-002 SHALL provide parameter STEPS_PER_MODE, default 8: ticks spent in each display mode; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port led_out, output, 4 bits: LED pattern, driven directly from a register with no combinational path from any input.

Function
REQ-006 SHALL contain a prescaler counter that counts 0..DIV-1 and wraps to 0.
REQ-007 SHALL assert the internal tick in the cycle where prescaler == DIV-1, so the first tick after reset release occurs on the DIV-th rising edge with rst_n high.
REQ-008 SHALL keep a tick counter for steps within the current mode, range 0..STEPS_PER_MODE-1.
REQ-009 SHALL implement a 4-state mode FSM in this fixed order: LEFT -> RIGHT -> COUNT -> BLINK -> LEFT.
REQ-010 SHALL keep led_out and all state unchanged on non-tick cycles.
REQ-011 On a tick with step < STEPS_PER_MODE-1, SHALL increment step and update led_out by the current mode rule:
- LEFT: rotate left, bit3 goes to bit0.
- RIGHT: rotate right, bit0 goes to bit3.
- COUNT: add 1 modulo 16; 1111 wraps to 0000.
- BLINK: bitwise invert.
REQ-012 On a tick with step == STEPS_PER_MODE-1, SHALL:
- clear step to 0;
- advance the FSM to the next mode;
- load led_out with the next mode's start pattern, without applying any mode rule that cycle.
REQ-013 Mode start patterns SHALL be: LEFT 0001, RIGHT 1000, COUNT 0000, BLINK 1111.
REQ-014 With STEPS_PER_MODE = 1, SHALL change mode and load the start pattern on every tick.
REQ-015 With DIV = 1, SHALL tick on every clock.
REQ-016 Illegal FSM encodings SHALL recover to LEFT with led_out = 0001 on the next clock.

Reset
REQ-017 When rst_n is low at a rising edge, SHALL set: prescaler = 0, step = 0, mode = LEFT, led_out = 0001.
REQ-018 Reset SHALL have priority over a tick in the same cycle.
REQ-019 Asserting reset mid-operation SHALL abort the current mode immediately, with no partial update.
REQ-020 led_out SHALL remain 0001 for as long as rst_n is held low.
REQ-021 Output SHALL be 0001 from the first rising edge sampled with rst_n low; before that first edge the output is undefined.

Verification
REQ-022 Reset and first ticks, defaults: hold rst_n low for 10 clocks then release:
- led_out = 0001 throughout reset and for release edges 1-3;
- becomes 0010 at edge 4;
- becomes 0100 at edge 8;
- becomes 1000 at edge 12.
REQ-023 Full mode sequence, defaults, 128 clocks after release; required led_out per tick 1..32:
- 0010,0100,1000,0001,0010,0100,1000;
- 1000 (RIGHT start at tick 8), 0100,0010,0001,1000,0100,0010,0001;
- 0000 (tick 16), 0001..0111 counting up;
- 1111 (tick 24), then alternating 0000/1111 through tick 31;
- 0001 (tick 32, back to LEFT).
REQ-024 Mid-operation reset: assert rst_n low for one clock at release edge 70 (during COUNT) -> led_out = 0001 on that edge, next change at edge 74 to 0010.
REQ-025 Parameter corners:
- DIV = 1, STEPS_PER_MODE = 1 -> led_out sequence per clock after release: 1000, 0000, 1111, 0001, repeating.
- DIV = 1, STEPS_PER_MODE = 16, COUNT mode -> counter reaches 1111 then BLINK start 1111; no intermediate 0000 wrap.
REQ-026 Stability check: between ticks, led_out shows no change on any clock edge; the bench compares against a cycle-accurate reference model for at least 1000 clocks with random single-cycle resets.
